// File: rtl/if_axi_bridge_pkg.sv
// Shared definitions for the fetch-bus to AXI4 read bridge and its helpers:
// AXI burst/response/size encodings, bridge state encoding, size mask helper.
package if_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_SIZE_B      = 2'd0;
  localparam logic [1:0] AXI_SIZE_H      = 2'd1;
  localparam logic [1:0] AXI_SIZE_W      = 2'd2;
  localparam logic [1:0] AXI_SIZE_D      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_R     = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } bridge_state_e;

  // Keep-mask for a right-justified value of the given transfer size.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] mask;
    case (size)
      AXI_SIZE_B: mask = 64'h0000_0000_0000_00FF;
      AXI_SIZE_H: mask = 64'h0000_0000_0000_FFFF;
      AXI_SIZE_W: mask = 64'h0000_0000_FFFF_FFFF;
      AXI_SIZE_D: mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default:    mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/if_data_align.sv
// Combinational read-data aligner: shifts the addressed bytes of a 64-bit
// beat down to bit 0 and zero-extends to the requested size.
// Shared between the fetch bridge and the LSU bridge.
module if_data_align
  import if_axi_bridge_pkg::*;
(
  input  logic [63:0] r_data,
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  output logic [63:0] data
);

  logic [63:0] shifted_s;

  // Byte-lane shift by the low address bits, then trim to the transfer size.
  always_comb begin
    shifted_s = r_data >> {addr_lo, 3'b000};
    data      = shifted_s & size_mask(size);
  end

endmodule

// File: rtl/if_axi_bridge.sv
// if_axi_bridge: converts single fetch requests into single-beat AXI4 reads.
// Only one transaction is ever outstanding, so rid filtering against AXI_ID
// is enough to pair beats with requests.
// Optional macro IF_AXI_BRIDGE_TIMEOUT_EN adds a watchdog that completes a
// stuck request with DECERR and then drains the late beat in ST_DRAIN.
module if_axi_bridge
  import if_axi_bridge_pkg::*;
#(
  parameter int AXI_ADDR_W = 64,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_ID     = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [63:0]           if_addr,
  input  logic [1:0]            if_size,
  output logic [63:0]           if_data_read,
  output logic [1:0]            if_resp,
  output logic                  axi_ar_valid,
  input  logic                  axi_ar_ready,
  output logic [AXI_ADDR_W-1:0] axi_ar_addr,
  output logic [AXI_ID_W-1:0]   axi_ar_id,
  output logic [7:0]            axi_ar_len,
  output logic [2:0]            axi_ar_size,
  output logic [1:0]            axi_ar_burst,
  input  logic                  axi_r_valid,
  output logic                  axi_r_ready,
  input  logic [AXI_DATA_W-1:0] axi_r_data,
  input  logic [1:0]            axi_r_resp,
  input  logic                  axi_r_last,
  input  logic [AXI_ID_W-1:0]   axi_r_id
);

  localparam logic [AXI_ID_W-1:0] ID_C      = AXI_ID_W'(AXI_ID);
  localparam logic [15:0]         TIMEOUT_C = 16'(TIMEOUT);

  bridge_state_e         state_r;
  logic [AXI_ADDR_W-1:0] addr_r;
  logic [1:0]            size_r;
  logic [63:0]           aligned_s;
  logic                  rid_match_s;
  logic                  unused_s;

  // AR fields come straight from the request latches, so they cannot move
  // while axi_ar_valid is high.
  assign axi_ar_addr  = addr_r;
  assign axi_ar_id    = ID_C;
  assign axi_ar_len   = 8'd0;
  assign axi_ar_size  = {1'b0, size_r};
  assign axi_ar_burst = AXI_BURST_INCR;

  if_data_align u_align (
    .r_data  (axi_r_data[63:0]),
    .addr_lo (addr_r[2:0]),
    .size    (size_r),
    .data    (aligned_s)
  );

`ifdef IF_AXI_BRIDGE_TIMEOUT_EN
  logic [15:0] cnt_r;
  logic [15:0] cnt_next_s;
  logic        tmo_s;
  logic        drain_r;
  logic        ar_tmo_r;

  // Watchdog compare and saturating increment.
  always_comb begin
    tmo_s      = (cnt_r >= (TIMEOUT_C - 16'd1));
    cnt_next_s = 16'd0;
    if (cnt_r == 16'hFFFF) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + 16'd1;
    end
  end

  // r_last is meaningless for len=0 transfers.
  assign unused_s = axi_r_last;
`else
  // r_last is meaningless for len=0 transfers; no watchdog in this build.
  assign unused_s = axi_r_last ^ TIMEOUT_C[0];
`endif

  assign rid_match_s = axi_r_valid && (axi_r_id == ID_C);

  // Bridge FSM with all handshake and completion outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      size_r       <= 2'd0;
      axi_ar_valid <= 1'b0;
      axi_r_ready  <= 1'b0;
      if_ready     <= 1'b0;
      if_data_read <= 64'd0;
      if_resp      <= AXI_RESP_OKAY;
`ifdef IF_AXI_BRIDGE_TIMEOUT_EN
      cnt_r        <= 16'd0;
      drain_r      <= 1'b0;
      ar_tmo_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if_ready <= 1'b0;
          if (if_valid) begin
            addr_r       <= if_addr[AXI_ADDR_W-1:0];
            size_r       <= if_size;
            axi_ar_valid <= 1'b1;
            state_r      <= ST_AR;
`ifdef IF_AXI_BRIDGE_TIMEOUT_EN
            cnt_r        <= 16'd0;
            drain_r      <= 1'b0;
            ar_tmo_r     <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_AR: begin
`ifdef IF_AXI_BRIDGE_TIMEOUT_EN
          cnt_r <= cnt_next_s;
          if (axi_ar_ready) begin
            axi_ar_valid <= 1'b0;
            if (ar_tmo_r) begin
              // Address already abandoned: report DECERR, then drain the beat.
              if_ready     <= 1'b1;
              if_data_read <= 64'd0;
              if_resp      <= AXI_RESP_DECERR;
              drain_r      <= 1'b1;
              state_r      <= ST_DONE;
            end else begin
              axi_r_ready <= 1'b1;
              state_r     <= ST_R;
            end
          end else if (tmo_s) begin
            // AXI forbids withdrawing valid, so keep waiting for ar_ready.
            ar_tmo_r <= 1'b1;
          end else begin
            state_r <= ST_AR;
          end
`else
          if (axi_ar_ready) begin
            axi_ar_valid <= 1'b0;
            axi_r_ready  <= 1'b1;
            state_r      <= ST_R;
          end else begin
            state_r <= ST_AR;
          end
`endif
        end
        ST_R: begin
`ifdef IF_AXI_BRIDGE_TIMEOUT_EN
          cnt_r <= cnt_next_s;
`endif
          if (rid_match_s) begin
            axi_r_ready  <= 1'b0;
            if_ready     <= 1'b1;
            if_data_read <= aligned_s;
            if_resp      <= axi_r_resp;
            state_r      <= ST_DONE;
          end
`ifdef IF_AXI_BRIDGE_TIMEOUT_EN
          else if (tmo_s) begin
            axi_r_ready  <= 1'b0;
            if_ready     <= 1'b1;
            if_data_read <= 64'd0;
            if_resp      <= AXI_RESP_DECERR;
            drain_r      <= 1'b1;
            state_r      <= ST_DONE;
          end
`endif
          else begin
            // Foreign-ID beats are consumed (r_ready high) and dropped.
            state_r <= ST_R;
          end
        end
        ST_DONE: begin
          if_ready <= 1'b0;
`ifdef IF_AXI_BRIDGE_TIMEOUT_EN
          if (drain_r) begin
            axi_r_ready <= 1'b1;
            state_r     <= ST_DRAIN;
          end else begin
            state_r <= ST_IDLE;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
`ifdef IF_AXI_BRIDGE_TIMEOUT_EN
        ST_DRAIN: begin
          if (rid_match_s) begin
            axi_r_ready <= 1'b0;
            drain_r     <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
`endif
        default: begin
          axi_ar_valid <= 1'b0;
          axi_r_ready  <= 1'b0;
          if_ready     <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
